// File: rtl/auth_responder_param.sv
`timescale 1ns/1ps
// USB Type-C authentication responder: decode/validate one request, fetch payload, hold response until ack.
// Latency: 2 cycles to an error response, 3+ cycles to a fetched response; new requests are ignored while busy.
module auth_responder_param #(
    parameter int MSG_LEN          = 512,
    parameter int NUM_SLOTS        = 8,
    parameter int PROTOCOL_VERSION = 1,
    parameter int FETCH_TIMEOUT    = 64,
    parameter int ACK_TIMEOUT      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_in,
    input  logic [MSG_LEN-1:0]    req_msg_in,
    input  logic                  busy_in,
    input  logic [NUM_SLOTS-1:0]  slot_mask_in,
    output logic                  payload_req_out,
    output logic [1:0]            payload_type_out,
    output logic [2:0]            payload_slot_out,
    input  logic                  payload_valid_in,
    input  logic [MSG_LEN-33:0]   payload_in,
    output logic                  resp_valid_out,
    output logic [MSG_LEN-1:0]    resp_msg_out,
    input  logic                  ack_in,
    output logic                  ack_timeout_out,
    output logic [7:0]            err_count_out,
    output logic                  busy_out
);
    localparam int PL_W   = MSG_LEN - 32;
    localparam int MAX_TO = (FETCH_TIMEOUT > ACK_TIMEOUT) ? FETCH_TIMEOUT : ACK_TIMEOUT;
    localparam int CW     = $clog2(MAX_TO + 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_TIMEOUT - 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
    localparam logic [7:0]    PV8        = 8'(PROTOCOL_VERSION);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_FETCH, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_ver;
    logic [7:0]          r_type;
    logic [7:0]          r_p1;
    logic [CW-1:0]       r_cnt;
    logic [MSG_LEN-1:0]  r_resp;
    logic [7:0]          r_err_cnt;
    logic                r_ack_to;

    logic [7:0]          w_err;
    logic                w_slot_ok;
    logic                w_is_dig;
    logic [7:0]          w_mask8;
    logic [31:0]         w_ok_hdr;
    logic                w_fetch_to;
    logic                w_ack_to;
    logic                w_unused;

    // Param2 and the request payload carry nothing this block needs.
    assign w_unused = ^req_msg_in[MSG_LEN-25:0];

    function automatic logic [31:0] err_hdr(input logic [7:0] code);
        return {PV8, 8'h7F, code, 8'h00};
    endfunction

    assign w_is_dig = (r_type == 8'h81);
    assign w_ok_hdr = {PV8, r_type & 8'h7F, w_is_dig ? 8'h00 : r_p1, w_is_dig ? w_mask8 : 8'h00};

    always_comb begin
        w_mask8   = 8'h00;
        w_slot_ok = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_mask8[i] = slot_mask_in[i];
            if (r_p1 == 8'(i) && slot_mask_in[i]) w_slot_ok = 1'b1;
        end
        w_err = 8'h00;
        if (r_ver != PV8)                                         w_err = 8'h02;
        else if (busy_in)                                         w_err = 8'h03;
        else if (r_type != 8'h81 && r_type != 8'h82 && r_type != 8'h83) w_err = 8'h01;
        else if (!w_is_dig && !w_slot_ok)                         w_err = 8'h01;
    end

    always_comb begin
        w_next     = r_state;
        w_fetch_to = 1'b0;
        w_ack_to   = 1'b0;
        case (r_state)
            S_IDLE:   if (req_valid_in) w_next = S_DECODE;
            S_DECODE: w_next = (w_err != 8'h00) ? S_RESP : S_FETCH;
            S_FETCH: begin
                // A payload on the timeout edge takes priority over the timeout.
                if (payload_valid_in) begin
                    w_next = S_RESP;
                end else if (r_cnt == FETCH_LAST) begin
                    w_next     = S_RESP;
                    w_fetch_to = 1'b1;
                end
            end
            S_RESP: begin
                if (ack_in) begin
                    w_next = S_IDLE;
                end else if (r_cnt == ACK_LAST) begin
                    w_next   = S_IDLE;
                    w_ack_to = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ver     <= 8'h00;
            r_type    <= 8'h00;
            r_p1      <= 8'h00;
            r_cnt     <= '0;
            r_resp    <= '0;
            r_err_cnt <= 8'h00;
            r_ack_to  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ack_to <= w_ack_to;
            // Counter measures residency in FETCH or RESP and restarts on every state change.
            if (w_next == r_state && (r_state == S_FETCH || r_state == S_RESP))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_in) begin
                        r_ver  <= req_msg_in[MSG_LEN-1 -: 8];
                        r_type <= req_msg_in[MSG_LEN-9 -: 8];
                        r_p1   <= req_msg_in[MSG_LEN-17 -: 8];
                    end
                end
                S_DECODE: begin
                    if (w_err != 8'h00) begin
                        r_resp <= {err_hdr(w_err), {PL_W{1'b0}}};
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (payload_valid_in) begin
                        r_resp <= {w_ok_hdr, payload_in};
                    end else if (w_fetch_to) begin
                        r_resp <= {err_hdr(8'h04), {PL_W{1'b0}}};
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
                S_RESP: if (w_next == S_IDLE) r_resp <= '0;
                default: ;
            endcase
        end
    end

    assign payload_req_out  = (r_state == S_FETCH);
    assign payload_type_out = (r_state == S_FETCH) ? r_type[1:0] : 2'd0;
    assign payload_slot_out = (r_state == S_FETCH && !w_is_dig) ? r_p1[2:0] : 3'd0;
    assign resp_valid_out   = (r_state == S_RESP);
    assign resp_msg_out     = r_resp;
    assign ack_timeout_out  = r_ack_to;
    assign err_count_out    = r_err_cnt;
    assign busy_out         = (r_state != S_IDLE);

endmodule

// File: tb/tb_auth_responder_param.sv
`timescale 1ns/1ps
// Directed bench for auth_responder_param: header decode, error paths, timeouts and counter saturation.
module tb_auth_responder_param;
    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid_in;
    logic [511:0] req_msg_in;
    logic         busy_in;
    logic [7:0]   slot_mask_in;
    logic         payload_req_out;
    logic [1:0]   payload_type_out;
    logic [2:0]   payload_slot_out;
    logic         payload_valid_in;
    logic [479:0] payload_in;
    logic         resp_valid_out;
    logic [511:0] resp_msg_out;
    logic         ack_in;
    logic         ack_timeout_out;
    logic [7:0]   err_count_out;
    logic         busy_out;

    int checks = 0;
    int errors = 0;

    localparam logic [479:0] PL_A = {15{32'hDEADBEEF}};
    localparam logic [479:0] PL_B = {15{32'h1234A5C3}};
    localparam logic [479:0] PL_Z = '0;

    auth_responder_param dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_msg_in(req_msg_in),
        .busy_in(busy_in), .slot_mask_in(slot_mask_in),
        .payload_req_out(payload_req_out), .payload_type_out(payload_type_out),
        .payload_slot_out(payload_slot_out), .payload_valid_in(payload_valid_in),
        .payload_in(payload_in), .resp_valid_out(resp_valid_out),
        .resp_msg_out(resp_msg_out), .ack_in(ack_in),
        .ack_timeout_out(ack_timeout_out), .err_count_out(err_count_out),
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] hdr);
        req_msg_in   = {hdr, PL_B};
        req_valid_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
    endtask

    task automatic do_ack();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid_in = 0; req_msg_in = '0; busy_in = 0; slot_mask_in = 0;
        payload_valid_in = 0; payload_in = '0; ack_in = 0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({resp_valid_out, payload_req_out, busy_out, ack_timeout_out, payload_type_out, payload_slot_out} !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0", {resp_valid_out, payload_req_out, busy_out, ack_timeout_out, payload_type_out, payload_slot_out});
        end
        checks++;
        if (resp_msg_out !== 512'd0 || err_count_out !== 8'd0) begin
            errors++; $display("FAIL reset_data: msg_hdr %h cnt %0d want 0", resp_msg_out[511:480], err_count_out);
        end
    endtask

    task automatic test_digests();
        slot_mask_in = 8'h05;
        send(32'h01810000);
        checks++;
        if (busy_out !== 1'b1 || payload_req_out !== 1'b0) begin
            errors++; $display("FAIL dig_decode: busy %b req %b want 1 0", busy_out, payload_req_out);
        end
        tick();
        checks++;
        if ({payload_req_out, payload_type_out, payload_slot_out, resp_valid_out} !== {1'b1, 2'd1, 3'd0, 1'b0}) begin
            errors++; $display("FAIL dig_fetch: req %b type %0d slot %0d rv %b want 1 1 0 0", payload_req_out, payload_type_out, payload_slot_out, resp_valid_out);
        end
        tick();
        payload_valid_in = 1'b1; payload_in = PL_A;
        tick();
        payload_valid_in = 1'b0;
        checks++;
        if (resp_valid_out !== 1'b1 || payload_req_out !== 1'b0 || resp_msg_out !== {32'h01010005, PL_A}) begin
            errors++; $display("FAIL dig_resp: rv %b req %b hdr %h want 1 0 01010005", resp_valid_out, payload_req_out, resp_msg_out[511:480]);
        end
        do_ack();
        checks++;
        if (resp_valid_out !== 1'b0 || resp_msg_out !== 512'd0 || busy_out !== 1'b0) begin
            errors++; $display("FAIL dig_ack: rv %b busy %b hdr %h want 0 0 0", resp_valid_out, busy_out, resp_msg_out[511:480]);
        end
    endtask

    task automatic test_bad_version();
        busy_in = 1'b1;
        send(32'h02810000);
        checks++;
        if (resp_valid_out !== 1'b0) begin
            errors++; $display("FAIL ver_early: rv %b want 0", resp_valid_out);
        end
        tick();
        busy_in = 1'b0;
        checks++;
        if (resp_valid_out !== 1'b1 || resp_msg_out !== {32'h017F0200, PL_Z} || err_count_out !== 8'd1) begin
            errors++; $display("FAIL ver_resp: rv %b hdr %h cnt %0d want 1 017f0200 1", resp_valid_out, resp_msg_out[511:480], err_count_out);
        end
        do_ack();
    endtask

    task automatic test_challenge();
        slot_mask_in = 8'h05;
        send(32'h01830300);
        tick();
        checks++;
        if (resp_msg_out !== {32'h017F0100, PL_Z} || err_count_out !== 8'd2) begin
            errors++; $display("FAIL chal_empty: hdr %h cnt %0d want 017f0100 2", resp_msg_out[511:480], err_count_out);
        end
        do_ack();
        slot_mask_in = 8'h0D;
        send(32'h01830300);
        tick();
        checks++;
        if (payload_req_out !== 1'b1 || payload_type_out !== 2'd3 || payload_slot_out !== 3'd3) begin
            errors++; $display("FAIL chal_fetch: req %b type %0d slot %0d want 1 3 3", payload_req_out, payload_type_out, payload_slot_out);
        end
        payload_valid_in = 1'b1; payload_in = PL_B;
        tick();
        payload_valid_in = 1'b0;
        checks++;
        if (resp_msg_out !== {32'h01030300, PL_B}) begin
            errors++; $display("FAIL chal_resp: hdr %h want 01030300", resp_msg_out[511:480]);
        end
        do_ack();
    endtask

    task automatic test_fetch_timeout();
        int cnt;
        send(32'h01820000);
        tick();
        cnt = 0;
        for (int i = 0; i < 100 && payload_req_out; i++) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 64) begin
            errors++; $display("FAIL fetch_to_len: got %0d cycles want 64", cnt);
        end
        checks++;
        if (resp_valid_out !== 1'b1 || resp_msg_out !== {32'h017F0400, PL_Z} || err_count_out !== 8'd3) begin
            errors++; $display("FAIL fetch_to_resp: rv %b hdr %h cnt %0d want 1 017f0400 3", resp_valid_out, resp_msg_out[511:480], err_count_out);
        end
        do_ack();
    endtask

    task automatic test_ack_timeout();
        int cnt, pulses;
        logic stable;
        send(32'h01900000);
        tick();
        cnt = 0; pulses = 0; stable = 1'b1;
        for (int i = 0; i < 300 && resp_valid_out; i++) begin
            cnt++;
            if (resp_msg_out !== {32'h017F0100, PL_Z}) stable = 1'b0;
            req_msg_in   = {32'h01810000, PL_B};
            req_valid_in = (i == 5);
            tick();
            pulses += int'(ack_timeout_out);
        end
        req_valid_in = 1'b0;
        tick();
        pulses += int'(ack_timeout_out);
        checks++;
        if (cnt !== 256 || !stable) begin
            errors++; $display("FAIL ack_to_len: got %0d cycles stable %b want 256 1", cnt, stable);
        end
        checks++;
        if (pulses !== 1 || busy_out !== 1'b0 || err_count_out !== 8'd4) begin
            errors++; $display("FAIL ack_to_pulse: pulses %0d busy %b cnt %0d want 1 0 4", pulses, busy_out, err_count_out);
        end
    endtask

    task automatic test_payload_wins();
        slot_mask_in = 8'h05;
        send(32'h01810000);
        tick();
        for (int i = 0; i < 63; i++) tick();
        checks++;
        if (payload_req_out !== 1'b1) begin
            errors++; $display("FAIL pl_wins_pre: req %b want 1", payload_req_out);
        end
        payload_valid_in = 1'b1; payload_in = PL_A;
        tick();
        payload_valid_in = 1'b0;
        checks++;
        if (resp_msg_out !== {32'h01010005, PL_A} || err_count_out !== 8'd4) begin
            errors++; $display("FAIL pl_wins: hdr %h cnt %0d want 01010005 4", resp_msg_out[511:480], err_count_out);
        end
    endtask

    task automatic test_ack_wins();
        for (int i = 0; i < 255; i++) tick();
        checks++;
        if (resp_valid_out !== 1'b1) begin
            errors++; $display("FAIL ack_wins_pre: rv %b want 1", resp_valid_out);
        end
        do_ack();
        checks++;
        if (resp_valid_out !== 1'b0 || ack_timeout_out !== 1'b0 || resp_msg_out !== 512'd0) begin
            errors++; $display("FAIL ack_wins: rv %b pulse %b want 0 0", resp_valid_out, ack_timeout_out);
        end
    endtask

    task automatic test_back_to_back_saturation();
        for (int i = 0; i < 250; i++) begin
            send(32'h01900000);
            tick();
            do_ack();
        end
        checks++;
        if (err_count_out !== 8'd254) begin
            errors++; $display("FAIL sat_pre: cnt %0d want 254", err_count_out);
        end
        for (int i = 0; i < 50; i++) begin
            send(32'h01900000);
            tick();
            do_ack();
        end
        checks++;
        if (err_count_out !== 8'd255) begin
            errors++; $display("FAIL sat: cnt %0d want 255", err_count_out);
        end
    endtask

    task automatic test_reset_mid_fetch();
        send(32'h01810000);
        tick();
        checks++;
        if (payload_req_out !== 1'b1) begin
            errors++; $display("FAIL rst_fetch_pre: req %b want 1", payload_req_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({resp_valid_out, payload_req_out, busy_out, ack_timeout_out, payload_type_out, payload_slot_out} !== 9'd0
            || resp_msg_out !== 512'd0 || err_count_out !== 8'd0) begin
            errors++; $display("FAIL rst_fetch: ctrl %b cnt %0d want 0 0", {resp_valid_out, payload_req_out, busy_out}, err_count_out);
        end
    endtask

    initial begin
        test_reset();
        test_digests();
        test_bad_version();
        test_challenge();
        test_fetch_timeout();
        test_ack_timeout();
        test_payload_wins();
        test_ack_wins();
        test_back_to_back_saturation();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
